pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the custom 16-bit core: the next generation of the PC block. It generates the fetch address. On each execute strobe it applies one of eight sequencing ops: increment, conditional skip, jump, conditional jump, call, return, return-from-interrupt and halt. It adds a hardware return stack shared by calls and interrupts, a configurable interrupt vector, halt/wake, and sticky stack error flags. It sits between the decode/ALU stage (op, condition, target) and instruction memory (pc).

## Interface
- PC_W, 12, program counter width in bits.
- STACK_DEPTH, 4, return-stack entries (≥1).
- RESET_PC, 0, PC value loaded on reset.
- INT_VEC, 12'h040, interrupt vector address (PC_W bits).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low.
- step  in  1  execute strobe; one op is consumed per cycle with step=1.
- op  in  3  sequencing op: 000 NEXT, 001 SKIP, 010 JMP, 011 JC, 100 CALL, 101 RET, 110 RETI, 111 HALT.
- cond  in  1  condition from ALU flags (zero/carry as selected by decode).
- target  in  PC_W  jump/call destination.
- irq  in  1  level interrupt request.
- ie  in  1  interrupt enable.
- pc  out  PC_W  current fetch address.
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH.
- in_isr  out  1  interrupt service in progress.
- halted  out  1  core halted.
- irq_ack  out  1  one-cycle pulse, the cycle an interrupt is taken.
- ovf_err  out  1  sticky: push attempted with stack full.
- unf_err  out  1  sticky: pop attempted with stack empty.

## Operation
- Reset (rst=0 at edge): pc=RESET_PC, sp=0, in_isr=0, halted=0, irq_ack=0, ovf_err=0, unf_err=0. Stack contents don't care. Reset overrides every other input.
- Interrupt take condition: irq & ie & ~in_isr & (sp<STACK_DEPTH) & (step | halted).
  - On take: push pc if not halted, or pc+1 if halted. Then pc=INT_VEC, in_isr=1, halted=0, irq_ack=1.
  - The current op is discarded. Take has priority over any op.
- If the stack is full, the interrupt is deferred. No error is flagged, and the op executes normally.
- Ops (step=1, no take, not halted):
  - NEXT: pc+1.
  - SKIP: cond ? pc+2 : pc+1.
  - JMP: target.
  - JC: cond ? target : pc+1.
  - CALL: if sp<STACK_DEPTH, push pc+1 and set pc=target. Otherwise set ovf_err=1 and pc+1 (call ignored).
  - RET: if sp>0, pop into pc. Otherwise set unf_err=1 and pc+1.
  - RETI: as RET, and also clear in_isr. On underflow, in_isr is still cleared.
  - HALT: pc unchanged, halted=1.
- While halted: step and op are ignored. Only reset or an interrupt take leaves halt.
- step=0 and no take: all state holds.
- Arithmetic: all PC sums are modulo 2^PC_W. 4095+1 wraps to 0; 4095+2 wraps to 1 (PC_W=12).
- Stack is LIFO. Push writes entry[sp] and increments sp; pop reads entry[sp-1] and decrements sp. Calls may nest inside an ISR up to the remaining depth.
- Error flags are sticky until reset.

## Timing
- Fully registered outputs. Effect of the inputs sampled at edge N is visible on pc/sp/flags after edge N.
- Throughput is one op per cycle, with back-to-back CALL/RET allowed. Zero-bubble: a RET after a CALL returns the address pushed one cycle earlier.
- irq_ack is high exactly one cycle, the cycle after the take edge. It coincides with pc=INT_VEC.
- irq is level-sampled. A request held across an ISR is re-taken on the first step after RETI clears in_isr.
- A take and a reset on the same edge: reset wins.
- Reset mid-ISR or mid-halt returns to reset values. Stack contents are abandoned.

## Test plan
- Reset then 5×NEXT: after rst=0 for one cycle pc=0, sp=0; then pc steps 1,2,3,4,5. step=0 for 3 cycles: pc holds 5.
- SKIP/JC: at pc=10, SKIP cond=1 -> 12. SKIP cond=0 -> 13. JC cond=1 target=0x200 -> 0x200. JC cond=0 -> 0x201. Wrap: pc=0xFFF SKIP cond=1 -> 0x001.
- Nested calls, depth 4: from pc=0x010 issue 4 CALLs to 0x100/0x200/0x300/0x400 -> sp=4. A fifth CALL -> ovf_err=1, pc=0x401. 4 RETs -> pc 0x301, 0x201, 0x101, 0x011, sp=0. A fifth RET -> unf_err=1, pc=0x012.
- Interrupt during JMP: pc=0x020, op=JMP target 0x300, irq=1, ie=1 -> pc=0x040, sp=1, in_isr=1, irq_ack pulse 1 cycle. A second irq while in_isr=1 is ignored. RETI -> pc=0x020, in_isr=0, sp=0, and the JMP re-executes.
- Halt/wake: HALT at pc=0x050 -> halted=1, pc=0x050, and NEXT with step=1 has no effect. Raise irq with step=0 -> pc=0x040, halted=0. RETI -> pc=0x051.
- Deferred irq and mid-ISR reset: sp=4 with irq=1 -> no take, NEXT executes, no error. RET brings sp to 3, then the next step takes the irq. During the ISR, assert rst=0 -> pc=0, sp=0, in_isr=0, errors cleared.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Sequencer bus: decode/ALU side drives the op and interrupt inputs,
// the sequencer returns the fetch address, stack occupancy and status.
interface pc_sequencer_if #(
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic            step;
  logic [2:0]      op;
  logic            cond;
  logic [PC_W-1:0] target;
  logic            irq;
  logic            ie;
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic            in_isr;
  logic            halted;
  logic            irq_ack;
  logic            ovf_err;
  logic            unf_err;

  modport master (
    output step, op, cond, target, irq, ie,
    input  pc, sp, in_isr, halted, irq_ack, ovf_err, unf_err
  );

  modport slave (
    input  step, op, cond, target, irq, ie,
    output pc, sp, in_isr, halted, irq_ack, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: eight sequencing ops, a return stack shared by
// calls and interrupts, halt/wake and sticky stack error flags.
module pc_sequencer #(
  parameter int              PC_W        = 12,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] INT_VEC     = 12'h040
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_SKIP = 3'b001,
    OP_JMP  = 3'b010,
    OP_JC   = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_RETI = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  logic [PC_W-1:0]  pc_r;
  logic [SP_W-1:0]  sp_r;
  logic             in_isr_r;
  logic             halted_r;
  logic             irq_ack_r;
  logic             ovf_err_r;
  logic             unf_err_r;
  logic [PC_W-1:0]  stack_r [STACK_DEPTH];

  logic [PC_W-1:0]  pc_inc1_s;
  logic [PC_W-1:0]  pc_inc2_s;
  logic             stack_full_s;
  logic             stack_empty_s;
  logic             take_s;
  logic [IDX_W-1:0] push_idx_s;
  logic [IDX_W-1:0] pop_idx_s;
  logic [PC_W-1:0]  pop_data_s;
  logic             push_en_s;
  logic [PC_W-1:0]  push_data_s;
  logic [PC_W-1:0]  pc_n_s;
  logic [SP_W-1:0]  sp_n_s;
  logic             in_isr_n_s;
  logic             halted_n_s;
  logic             irq_ack_n_s;
  logic             ovf_err_n_s;
  logic             unf_err_n_s;

  assign pc_inc1_s     = pc_r + PC_W'(1);
  assign pc_inc2_s     = pc_r + PC_W'(2);
  assign stack_full_s  = (sp_r == SP_FULL);
  assign stack_empty_s = (sp_r == SP_W'(0));
  assign push_idx_s    = sp_r[IDX_W-1:0];
  assign pop_idx_s     = push_idx_s - IDX_W'(1);
  assign pop_data_s    = stack_r[pop_idx_s];
  // A full stack defers the interrupt rather than flagging an error.
  assign take_s = bus.irq & bus.ie & ~in_isr_r & ~stack_full_s & (bus.step | halted_r);

  // Next-state selection: interrupt take, then halt hold, then the stepped op.
  always_comb begin
    pc_n_s      = pc_r;
    sp_n_s      = sp_r;
    in_isr_n_s  = in_isr_r;
    halted_n_s  = halted_r;
    irq_ack_n_s = 1'b0;
    ovf_err_n_s = ovf_err_r;
    unf_err_n_s = unf_err_r;
    push_en_s   = 1'b0;
    push_data_s = pc_r;
    if (take_s) begin
      push_en_s   = 1'b1;
      push_data_s = halted_r ? pc_inc1_s : pc_r;
      sp_n_s      = sp_r + SP_W'(1);
      pc_n_s      = INT_VEC;
      in_isr_n_s  = 1'b1;
      halted_n_s  = 1'b0;
      irq_ack_n_s = 1'b1;
    end else if (halted_r || !bus.step) begin
      pc_n_s = pc_r;
    end else begin
      case (op_e'(bus.op))
        OP_NEXT: pc_n_s = pc_inc1_s;
        OP_SKIP: pc_n_s = bus.cond ? pc_inc2_s : pc_inc1_s;
        OP_JMP:  pc_n_s = bus.target;
        OP_JC:   pc_n_s = bus.cond ? bus.target : pc_inc1_s;
        OP_CALL: begin
          if (!stack_full_s) begin
            push_en_s   = 1'b1;
            push_data_s = pc_inc1_s;
            sp_n_s      = sp_r + SP_W'(1);
            pc_n_s      = bus.target;
          end else begin
            ovf_err_n_s = 1'b1;
            pc_n_s      = pc_inc1_s;
          end
        end
        OP_RET, OP_RETI: begin
          if (!stack_empty_s) begin
            sp_n_s = sp_r - SP_W'(1);
            pc_n_s = pop_data_s;
          end else begin
            unf_err_n_s = 1'b1;
            pc_n_s      = pc_inc1_s;
          end
          if (op_e'(bus.op) == OP_RETI) begin
            in_isr_n_s = 1'b0;
          end else begin
            in_isr_n_s = in_isr_r;
          end
        end
        OP_HALT: halted_n_s = 1'b1;
        default: pc_n_s = pc_r;
      endcase
    end
  end

  // Architectural state and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r      <= RESET_PC;
      sp_r      <= SP_W'(0);
      in_isr_r  <= 1'b0;
      halted_r  <= 1'b0;
      irq_ack_r <= 1'b0;
      ovf_err_r <= 1'b0;
      unf_err_r <= 1'b0;
    end else begin
      pc_r      <= pc_n_s;
      sp_r      <= sp_n_s;
      in_isr_r  <= in_isr_n_s;
      halted_r  <= halted_n_s;
      irq_ack_r <= irq_ack_n_s;
      ovf_err_r <= ovf_err_n_s;
      unf_err_r <= unf_err_n_s;
    end
  end

  // Return-stack storage; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (rst && push_en_s) begin
      stack_r[push_idx_s] <= push_data_s;
    end
  end

  assign bus.pc      = pc_r;
  assign bus.sp      = sp_r;
  assign bus.in_isr  = in_isr_r;
  assign bus.halted  = halted_r;
  assign bus.irq_ack = irq_ack_r;
  assign bus.ovf_err = ovf_err_r;
  assign bus.unf_err = unf_err_r;
endmodule
